led_frame_buffer: RTL and testbench

Double-buffered pixel memory between the SPI word receiver and the WS2812 serializer. Captures 16-bit words from the SPI receiver's data/address/write-strobe bus into a back buffer while the serializer reads the front buffer. A control-word write requests a buffer swap, which commits only at the serializer's frame boundary, so a displayed frame never tears.

---
 rtl/led_frame_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_led_frame_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered pixel RAM between the SPI word receiver
// and the WS2812 serializer. SPI writes fill the back buffer; a control-word
// swap request commits only while frame_sync is high, so frames never tear.
// Optional build macro LED_FRAME_BUFFER_COPY_EN: after each commit, the new
// front buffer is copied into the new back buffer. This lets the host send
// partial updates.
module led_frame_buffer #(
  parameter int LED_WORDS  = 1024,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_WIDTH   = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           spi_data,
  input  logic [ADDR_WIDTH-1:0] spi_address,
  input  logic                  spi_write_strobe,
  input  logic [RD_WIDTH-1:0]   rd_address,
  output logic [15:0]           rd_data,
  input  logic                  frame_sync,
  output logic [ADDR_WIDTH-1:0] led_count,
  output logic                  front_select,
  output logic                  swap_pending,
  output logic [7:0]            frame_count,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] WORDS_A    = ADDR_WIDTH'(LED_WORDS);
  localparam logic [RD_WIDTH:0]     WORDS_R    = (RD_WIDTH+1)'(LED_WORDS);
  localparam logic [15:0]           WORDS_16   = 16'(LED_WORDS);
  localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = '1;

`ifdef LED_FRAME_BUFFER_COPY_EN
  typedef enum logic [1:0] {IDLE, PENDING, COPY, DRAIN} state_t;
  localparam logic [RD_WIDTH-1:0] LAST_WORD = RD_WIDTH'(LED_WORDS - 1);
`else
  typedef enum logic {IDLE, PENDING} state_t;
`endif

  // Physical index is {buffer, word}; the word field spans the full read
  // address range, so only the first LED_WORDS of each half are used.
  logic [15:0] mem [2**(RD_WIDTH+1)];

  state_t state_q, state_d;
  logic   commit;

  logic [RD_WIDTH-1:0] word_addr;
  logic pix_wr, cnt_wr, ctrl_wr, swap_req;

  logic                mem_we;
  logic [RD_WIDTH:0]   mem_waddr;
  logic [15:0]         mem_wdata;

  assign word_addr = spi_address[RD_WIDTH-1:0];
  assign pix_wr    = spi_write_strobe && (spi_address < WORDS_A);
  assign cnt_wr    = spi_write_strobe && (spi_address == COUNT_ADDR);
  assign ctrl_wr   = spi_write_strobe && (spi_address == CTRL_ADDR);
  assign swap_req  = ctrl_wr && spi_data[0];

`ifdef LED_FRAME_BUFFER_COPY_EN
  logic                ovf_clr;
  logic [RD_WIDTH-1:0] copy_idx;
  logic                copy_phase;
  logic [15:0]         copy_rdata;
  logic                hold_valid;
  logic [RD_WIDTH-1:0] hold_addr;
  logic [15:0]         hold_data;
  logic                overflow_q;

  assign ovf_clr  = ctrl_wr && spi_data[1];
  assign busy     = (state_q == COPY) || (state_q == DRAIN);
  assign overflow = overflow_q;
`else
  assign busy     = 1'b0;
  assign overflow = 1'b0;
`endif

  // Swap FSM next state; commit only from PENDING so a request and
  // frame_sync in the same cycle still waits for a later frame gap.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:    if (swap_req || swap_pending) state_d = PENDING;
      PENDING: if (frame_sync) begin
        commit = 1'b1;
`ifdef LED_FRAME_BUFFER_COPY_EN
        state_d = COPY;
`else
        state_d = IDLE;
`endif
      end
`ifdef LED_FRAME_BUFFER_COPY_EN
      // A write landing on the final copy cycle still needs draining.
      COPY:    if (copy_phase && copy_idx == LAST_WORD)
                 state_d = (hold_valid || pix_wr) ? DRAIN : IDLE;
      DRAIN:   if (!pix_wr) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Single RAM write port: copy engine, then held word, then live SPI writes.
  always_comb begin
    mem_we    = pix_wr;
    mem_waddr = {~front_select, word_addr};
    mem_wdata = spi_data;
`ifdef LED_FRAME_BUFFER_COPY_EN
    case (state_q)
      COPY: begin
        mem_we    = copy_phase;
        mem_waddr = {~front_select, copy_idx};
        mem_wdata = copy_rdata;
      end
      DRAIN: begin
        mem_we    = 1'b1;
        mem_waddr = {~front_select, hold_addr};
        mem_wdata = hold_data;
      end
      default: ;
    endcase
`endif
  end

  // RAM write port (and copy read port); contents are not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
`ifdef LED_FRAME_BUFFER_COPY_EN
    copy_rdata <= mem[{front_select, copy_idx}];
`endif
  end

  // Serializer read port: registered, out-of-range words read as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              rd_data <= '0;
    else if ({1'b0, rd_address} < WORDS_R)  rd_data <= mem[{front_select, rd_address}];
    else                                    rd_data <= '0;
  end

  // FSM state, swap bookkeeping and the led_count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      front_select <= 1'b0;
      swap_pending <= 1'b0;
      frame_count  <= '0;
      led_count    <= WORDS_A;
    end else begin
      state_q <= state_d;
      // Commit wins over a coincident request: repeated requests collapse.
      if (commit) begin
        front_select <= ~front_select;
        frame_count  <= frame_count + 8'd1;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (cnt_wr)
        led_count <= (spi_data > WORDS_16) ? WORDS_A : spi_data[ADDR_WIDTH-1:0];
    end
  end

`ifdef LED_FRAME_BUFFER_COPY_EN
  // Copy engine: read phase then write phase per word; hold register absorbs
  // SPI pixel writes while the write port is owned by the copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      copy_idx   <= '0;
      copy_phase <= 1'b0;
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (ovf_clr) overflow_q <= 1'b0;
      if (commit) begin
        copy_idx   <= '0;
        copy_phase <= 1'b0;
      end else if (state_q == COPY) begin
        copy_phase <= ~copy_phase;
        if (copy_phase) copy_idx <= copy_idx + 1'b1;
      end
      if (state_q == COPY && pix_wr) begin
        hold_valid <= 1'b1;
        hold_addr  <= word_addr;
        hold_data  <= spi_data;
        if (hold_valid) overflow_q <= 1'b1;
      end else if (state_q == DRAIN) begin
        // The held word drains this cycle, so a new write simply refills it.
        if (pix_wr) begin
          hold_addr <= word_addr;
          hold_data <= spi_data;
        end else begin
          hold_valid <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer (default parameters).
module tb_led_frame_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] spi_data = '0;
  logic [10:0] spi_address = '0;
  logic        spi_write_strobe = 1'b0;
  logic [9:0]  rd_address = '0;
  logic [15:0] rd_data;
  logic        frame_sync = 1'b0;
  logic [10:0] led_count;
  logic        front_select;
  logic        swap_pending;
  logic [7:0]  frame_count;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  led_frame_buffer dut (
    .clock(clock), .reset(reset),
    .spi_data(spi_data), .spi_address(spi_address),
    .spi_write_strobe(spi_write_strobe),
    .rd_address(rd_address), .rd_data(rd_data),
    .frame_sync(frame_sync), .led_count(led_count),
    .front_select(front_select), .swap_pending(swap_pending),
    .frame_count(frame_count), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic spi_write(input logic [10:0] a, input logic [15:0] d);
    spi_address = a; spi_data = d; spi_write_strobe = 1'b1;
    tick();
    spi_write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [15:0] d);
    rd_address = a;
    tick();
    d = rd_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    n_checks++;
    if (busy) begin n_fail++; $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n); end
  endtask

  task automatic do_swap();
    spi_write(11'h7FF, 16'h0001);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    wait_idle();
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    n_checks++; if (front_select !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %b want 0", front_select); end
    n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_checks++; if (led_count !== 11'd1024) begin n_fail++; $display("FAIL reset_led_count: got %0d want 1024", led_count); end
    n_checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b overflow %b want 0 0", busy, overflow); end
  endtask

  task automatic test_swap();
    logic [15:0] d;
    spi_write(11'd5, 16'hAAAA);          // back = buffer 1
    do_swap();
    n_checks++; if (front_select !== 1'b1 || frame_count !== 8'd1) begin n_fail++; $display("FAIL swap1: front %b count %0d want 1 1", front_select, frame_count); end
    spi_write(11'd5, 16'h1234);          // back = buffer 0
    rd(10'd5, d);
    n_checks++; if (d !== 16'hAAAA) begin n_fail++; $display("FAIL swap_old_front: got %h want AAAA", d); end
    spi_write(11'h7FF, 16'h0001);
    n_checks++; if (swap_pending !== 1'b1 || front_select !== 1'b1) begin n_fail++; $display("FAIL swap_pending_set: pending %b front %b want 1 1", swap_pending, front_select); end
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    n_checks++; if (front_select !== 1'b0 || swap_pending !== 1'b0 || frame_count !== 8'd2) begin n_fail++; $display("FAIL swap_commit: front %b pending %b count %0d want 0 0 2", front_select, swap_pending, frame_count); end
    wait_idle();
    rd(10'd5, d);
    n_checks++; if (d !== 16'h1234) begin n_fail++; $display("FAIL swap_new_front: got %h want 1234", d); end
  endtask

  task automatic test_sync_collision();
    // Control write and frame_sync in the same cycle: no commit yet.
    spi_address = 11'h7FF; spi_data = 16'h0001; spi_write_strobe = 1'b1; frame_sync = 1'b1;
    tick();
    spi_write_strobe = 1'b0;
    n_checks++; if (front_select !== 1'b0 || swap_pending !== 1'b1 || frame_count !== 8'd2) begin n_fail++; $display("FAIL collide_no_commit: front %b pending %b count %0d want 0 1 2", front_select, swap_pending, frame_count); end
    tick();
    frame_sync = 1'b0;
    n_checks++; if (front_select !== 1'b1 || swap_pending !== 1'b0 || frame_count !== 8'd3) begin n_fail++; $display("FAIL collide_commit: front %b pending %b count %0d want 1 0 3", front_select, swap_pending, frame_count); end
    wait_idle();
  endtask

  task automatic test_count_and_ignored();
    logic [15:0] d;
    spi_write(11'h7FE, 16'd300);
    n_checks++; if (led_count !== 11'd300) begin n_fail++; $display("FAIL led_count_300: got %0d want 300", led_count); end
    spi_write(11'h7FE, 16'd2000);
    n_checks++; if (led_count !== 11'd1024) begin n_fail++; $display("FAIL led_count_clamp: got %0d want 1024", led_count); end
    spi_write(11'd476, 16'h5555);        // back buffer (0) word 476
    spi_write(11'd1500, 16'h1234);       // unmapped; must not alias onto 476
    spi_write(11'h7FF, 16'h0000);        // zero control word does nothing
    n_checks++; if (swap_pending !== 1'b0 || led_count !== 11'd1024 || front_select !== 1'b1) begin n_fail++; $display("FAIL ignored_flags: pending %b led_count %0d front %b want 0 1024 1", swap_pending, led_count, front_select); end
    do_swap();
    rd(10'd476, d);
    n_checks++; if (d !== 16'h5555) begin n_fail++; $display("FAIL ignored_ram: got %h want 5555", d); end
  endtask

  task automatic test_double_request();
    logic [7:0] fc;
    fc = frame_count;
    spi_write(11'h7FF, 16'h0001);
    spi_write(11'h7FF, 16'h0003);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    wait_idle();
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    n_checks++; if (frame_count !== fc + 8'd1 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL double_request: count %0d pending %b want %0d 0", frame_count, swap_pending, fc + 8'd1); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    spi_write(11'h7FF, 16'h0001);
    // Pixel write on the commit edge lands in the buffer that becomes front.
    spi_address = 11'd7; spi_data = 16'hBEEF; spi_write_strobe = 1'b1; frame_sync = 1'b1;
    tick();
    spi_write_strobe = 1'b0; frame_sync = 1'b0;
    wait_idle();
    rd(10'd7, d);
    n_checks++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL write_on_commit: got %h want BEEF", d); end
    spi_write(11'd8, 16'h0808);
    spi_write(11'd9, 16'h0909);
    do_swap();
    rd(10'd8, d);
    n_checks++; if (d !== 16'h0808) begin n_fail++; $display("FAIL b2b_word8: got %h want 0808", d); end
    rd(10'd9, d);
    n_checks++; if (d !== 16'h0909) begin n_fail++; $display("FAIL b2b_word9: got %h want 0909", d); end
  endtask

  task automatic test_reset_mid();
    spi_write(11'h7FE, 16'd10);
    spi_write(11'h7FF, 16'h0001);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++; if (swap_pending !== 1'b0 || frame_count !== 8'd0 || front_select !== 1'b0 || led_count !== 11'd1024) begin n_fail++; $display("FAIL reset_mid: pending %b count %0d front %b led_count %0d want 0 0 0 1024", swap_pending, frame_count, front_select, led_count); end
    tick();
    reset = 1'b0;
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    n_checks++; if (front_select !== 1'b0 || frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_mid_no_commit: front %b count %0d want 0 0", front_select, frame_count); end
  endtask

`ifndef LED_FRAME_BUFFER_COPY_EN
  task automatic test_wrap();
    for (int i = 0; i < 256; i++) do_swap();
    n_checks++; if (frame_count !== 8'd0 || front_select !== 1'b0) begin n_fail++; $display("FAIL frame_count_wrap: count %0d front %b want 0 0", frame_count, front_select); end
  endtask
`else
  task automatic test_copy();
    logic [15:0] d;
    int n;
    apply_reset();
    for (int i = 0; i < 16; i++) spi_write(11'(i), 16'hC000 + 16'(i));   // buffer 1
    spi_write(11'h7FF, 16'h0001);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;                        // front = 1, copy 1 -> 0
    n = 1;
    while (busy && n < 5000) begin
      if (n >= 10 && n <= 12) begin
        spi_address = 11'(n); spi_data = 16'hD000 + 16'(n); spi_write_strobe = 1'b1;
      end
      tick();
      spi_write_strobe = 1'b0;
      if (busy) n++;
    end
    n_checks++; if (n < 2048 || n > 2051) begin n_fail++; $display("FAIL copy_busy_len: got %0d cycles want 2048..2051", n); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL copy_overflow: got %b want 1", overflow); end
    do_swap();                                                           // front = 0 (copied)
    rd(10'd12, d);
    n_checks++; if (d !== 16'hD00C) begin n_fail++; $display("FAIL copy_held_word: got %h want D00C", d); end
    rd(10'd10, d);
    n_checks++; if (d !== 16'hC00A) begin n_fail++; $display("FAIL copy_lost_word: got %h want C00A", d); end
    rd(10'd3, d);
    n_checks++; if (d !== 16'hC003) begin n_fail++; $display("FAIL copy_word3: got %h want C003", d); end
    spi_write(11'h7FF, 16'h0002);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL copy_ovf_clear: got %b want 0", overflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_swap();
    test_sync_collision();
    test_count_and_ignored();
    test_double_request();
    test_back_to_back();
    test_reset_mid();
`ifndef LED_FRAME_BUFFER_COPY_EN
    apply_reset();
    test_wrap();
`else
    test_copy();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
